// File: rtl/hdr_cls_pkg.sv
// Shared definitions for header_classifier: FSM state encoding and default parameters.
package hdr_cls_pkg;

   localparam int unsigned DefDataW    = 8;
   localparam int unsigned DefHdrBeats = 4;
   localparam int unsigned DefTypeBeat = 0;
   localparam int unsigned DefTypeLsb  = 0;
   localparam int unsigned DefTypeW    = 8;
   localparam int unsigned DefNumTypes = 2;
   localparam int unsigned DefLenBeat  = 1;
   localparam int unsigned DefLenLsb   = 0;
   localparam int unsigned DefLenW     = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHdr  = 2'd1,
      StPass = 2'd2,
      StDrop = 2'd3
   } state_t;

endpackage

// File: rtl/hdr_type_decode.sv
// Combinational type-field decoder: one-hot for types below NUM_TYPES, unknown flag otherwise.
module hdr_type_decode #(
   parameter int unsigned TYPE_W    = 8,
   parameter int unsigned NUM_TYPES = 2
) (
   input  logic [TYPE_W-1:0]    type_field,
   output logic [NUM_TYPES-1:0] onehot,
   output logic                 unknown
);

   always_comb begin
      onehot  = '0;
      unknown = 1'b1;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (type_field == TYPE_W'(i)) begin
            onehot[i] = 1'b1;
            unknown   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/header_classifier.sv
// Streaming header classifier: captures HDR_BEATS header beats, decodes the type and forwards
// the payload of known types. Optional payload-length check under `HDR_LEN_CHECK_EN.
module header_classifier
   import hdr_cls_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned HDR_BEATS = DefHdrBeats,
   parameter int unsigned TYPE_BEAT = DefTypeBeat,
   parameter int unsigned TYPE_LSB  = DefTypeLsb,
   parameter int unsigned TYPE_W    = DefTypeW,
   parameter int unsigned NUM_TYPES = DefNumTypes,
   parameter int unsigned LEN_BEAT  = DefLenBeat,
   parameter int unsigned LEN_LSB   = DefLenLsb,
   parameter int unsigned LEN_W     = DefLenW
) (
   input  logic                        clock,
   input  logic                        sclr_n,
   input  logic                        in_valid,
   input  logic                        in_sop,
   input  logic                        in_eop,
   input  logic [DATA_W-1:0]           in_data,
   output logic                        out_valid,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic [DATA_W-1:0]           out_data,
   output logic                        hdr_done,
   output logic [HDR_BEATS*DATA_W-1:0] hdr_data,
   output logic [NUM_TYPES-1:0]        type_onehot,
   output logic                        type_unknown,
   output logic                        runt_err,
   output logic                        len_err
);

   localparam int unsigned CNT_W    = $clog2(HDR_BEATS);
   localparam int unsigned HDR_W    = HDR_BEATS * DATA_W;
   localparam int unsigned TYPE_POS = (HDR_BEATS - 1 - TYPE_BEAT) * DATA_W + TYPE_LSB;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HDR_BEATS - 1);

   state_t                 state;
   logic [CNT_W-1:0]       beat_cnt;
   logic                   first_beat;
   logic [HDR_W-1:0]       hdr_next;
   logic [HDR_W-1:0]       hdr_first;
   logic [NUM_TYPES-1:0]   dec_onehot;
   logic                   dec_unknown;
   logic                   start;

   assign start     = in_valid & in_sop;
   assign hdr_first = {in_data, {(HDR_W - DATA_W){1'b0}}};

   // Header with the current beat merged into its slot, so decode sees the last beat too.
   always_comb begin
      hdr_next = hdr_data;
      for (int i = 0; i < HDR_BEATS; i++) begin
         if (beat_cnt == CNT_W'(i)) begin
            hdr_next[(HDR_BEATS - 1 - i) * DATA_W +: DATA_W] = in_data;
         end
      end
   end

   hdr_type_decode #(
      .TYPE_W    (TYPE_W),
      .NUM_TYPES (NUM_TYPES)
   ) u_type_decode (
      .type_field (hdr_next[TYPE_POS +: TYPE_W]),
      .onehot     (dec_onehot),
      .unknown    (dec_unknown)
   );

`ifdef HDR_LEN_CHECK_EN
   localparam int unsigned LEN_POS = (HDR_BEATS - 1 - LEN_BEAT) * DATA_W + LEN_LSB;
   logic [LEN_W-1:0] len_field;
   logic [LEN_W-1:0] pay_cnt;
   logic [LEN_W-1:0] pay_inc;
   logic             len_err_q;

   assign pay_inc = (&pay_cnt) ? pay_cnt : pay_cnt + 1'b1;
   assign len_err = len_err_q;
`else
   assign len_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         state        <= StIdle;
         beat_cnt     <= '0;
         first_beat   <= 1'b0;
         hdr_data     <= '0;
         type_onehot  <= '0;
         type_unknown <= 1'b0;
         hdr_done     <= 1'b0;
         runt_err     <= 1'b0;
         out_valid    <= 1'b0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         out_data     <= '0;
`ifdef HDR_LEN_CHECK_EN
         len_field    <= '0;
         pay_cnt      <= '0;
         len_err_q    <= 1'b0;
`endif
      end else begin
         hdr_done  <= 1'b0;
         runt_err  <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
`ifdef HDR_LEN_CHECK_EN
         len_err_q <= 1'b0;
`endif
         if (start) begin
            // SOP always restarts capture; a header cut short by it or by EOP is a runt.
            hdr_data     <= hdr_first;
            beat_cnt     <= CNT_W'(1);
            type_onehot  <= '0;
            type_unknown <= 1'b0;
            runt_err     <= (state == StHdr) | in_eop;
            state        <= in_eop ? StIdle : StHdr;
         end else if (in_valid) begin
            unique case (state)
               StHdr: begin
                  hdr_data <= hdr_next;
                  if (beat_cnt == LAST) begin
                     hdr_done     <= 1'b1;
                     type_onehot  <= dec_onehot;
                     type_unknown <= dec_unknown;
                     first_beat   <= 1'b1;
`ifdef HDR_LEN_CHECK_EN
                     len_field <= hdr_next[LEN_POS +: LEN_W];
                     pay_cnt   <= '0;
                     if (in_eop && !dec_unknown) begin
                        len_err_q <= (hdr_next[LEN_POS +: LEN_W] != '0);
                     end
`endif
                     if (in_eop) begin
                        state <= StIdle;
                     end else begin
                        state <= dec_unknown ? StDrop : StPass;
                     end
                  end else if (in_eop) begin
                     runt_err <= 1'b1;
                     state    <= StIdle;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               StPass: begin
                  out_valid  <= 1'b1;
                  out_data   <= in_data;
                  out_sop    <= first_beat;
                  out_eop    <= in_eop;
                  first_beat <= 1'b0;
`ifdef HDR_LEN_CHECK_EN
                  pay_cnt <= pay_inc;
                  if (in_eop) begin
                     len_err_q <= (pay_inc != len_field);
                  end
`endif
                  if (in_eop) begin
                     state <= StIdle;
                  end
               end
               StDrop: begin
                  if (in_eop) begin
                     state <= StIdle;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_header_classifier.sv
// Directed self-checking bench for header_classifier (default parameters); length checks run
// only when HDR_LEN_CHECK_EN is defined.
module tb_header_classifier;

   logic        clock = 1'b0;
   logic        sclr_n;
   logic        in_valid, in_sop, in_eop;
   logic [7:0]  in_data;
   logic        out_valid, out_sop, out_eop;
   logic [7:0]  out_data;
   logic        hdr_done;
   logic [31:0] hdr_data;
   logic [1:0]  type_onehot;
   logic        type_unknown, runt_err, len_err;

   int checks = 0;
   int errors = 0;

   header_classifier dut (
      .clock        (clock),
      .sclr_n       (sclr_n),
      .in_valid     (in_valid),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_data     (out_data),
      .hdr_done     (hdr_done),
      .hdr_data     (hdr_data),
      .type_onehot  (type_onehot),
      .type_unknown (type_unknown),
      .runt_err     (runt_err),
      .len_err      (len_err)
   );

   always #5 clock = ~clock;

   // Apply one beat, then sample 1 time unit after the edge that registers it.
   task automatic drive(input logic v, input logic sop, input logic eop, input logic [7:0] d);
      in_valid = v;
      in_sop   = sop;
      in_eop   = eop;
      in_data  = d;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      sclr_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h01);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data, hdr_done, type_onehot, type_unknown,
           runt_err, len_err} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", {out_valid, out_sop, out_eop, out_data,
                  hdr_done, type_onehot, type_unknown, runt_err, len_err});
      end
      checks++;
      if (hdr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_hdr_data got %h want 00000000", hdr_data);
      end
      sclr_n = 1'b1;
   endtask

   task automatic test_known;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      checks++;
      if (hdr_done !== 1'b0) begin
         errors++;
         $display("FAIL known_early_done got %b want 0", hdr_done);
      end
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      drive(1'b1, 1'b0, 1'b0, 8'hBB);
      drive(1'b1, 1'b0, 1'b0, 8'hCC);
      checks++;
      if ({hdr_done, type_onehot, type_unknown, out_valid} !== 5'b1_01_0_0) begin
         errors++;
         $display("FAIL known_decode got %b want 10100",
                  {hdr_done, type_onehot, type_unknown, out_valid});
      end
      checks++;
      if (hdr_data !== 32'h00AABBCC) begin
         errors++;
         $display("FAIL known_hdr_data got %h want 00aabbcc", hdr_data);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h11);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data, hdr_done} !== {3'b110, 8'h11, 1'b0}) begin
         errors++;
         $display("FAIL known_pay0 got %b want %b", {out_valid, out_sop, out_eop, out_data,
                  hdr_done}, {3'b110, 8'h11, 1'b0});
      end
      drive(1'b1, 1'b0, 1'b1, 8'h22);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b101, 8'h22}) begin
         errors++;
         $display("FAIL known_pay1 got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b101, 8'h22});
      end
`ifndef HDR_LEN_CHECK_EN
      checks++;
      if (len_err !== 1'b0) begin
         errors++;
         $display("FAIL len_err_tied got %b want 0", len_err);
      end
`endif
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL known_after_eop out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_unknown;
      drive(1'b1, 1'b1, 1'b0, 8'h05);
      drive(1'b1, 1'b0, 1'b0, 8'h01);
      drive(1'b1, 1'b0, 1'b0, 8'h02);
      drive(1'b1, 1'b0, 1'b0, 8'h03);
      checks++;
      if ({hdr_done, type_onehot, type_unknown} !== 4'b1_00_1) begin
         errors++;
         $display("FAIL unknown_decode got %b want 1001", {hdr_done, type_onehot, type_unknown});
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, (i == 2), 8'h40 + 8'(i));
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unknown_drop beat %0d out_valid got %b want 0", i, out_valid);
         end
      end
      // Stray beats after the dropped packet must be ignored in IDLE.
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      drive(1'b1, 1'b0, 1'b0, 8'h77);
      checks++;
      if ({hdr_done, out_valid, type_unknown} !== 3'b001) begin
         errors++;
         $display("FAIL unknown_idle got %b want 001", {hdr_done, out_valid, type_unknown});
      end
   endtask

   task automatic test_runt_eop;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      drive(1'b1, 1'b0, 1'b1, 8'hBB);
      checks++;
      if ({runt_err, hdr_done} !== 2'b10) begin
         errors++;
         $display("FAIL runt_eop got %b want 10", {runt_err, hdr_done});
      end
      drive(1'b1, 1'b0, 1'b0, 8'hCC);
      checks++;
      if ({runt_err, hdr_done, out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL runt_eop_after got %b want 000", {runt_err, hdr_done, out_valid});
      end
   endtask

   task automatic test_runt_restart;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      drive(1'b1, 1'b1, 1'b0, 8'h01);
      checks++;
      if ({runt_err, hdr_done} !== 2'b10) begin
         errors++;
         $display("FAIL runt_sop got %b want 10", {runt_err, hdr_done});
      end
      drive(1'b1, 1'b0, 1'b0, 8'h11);
      drive(1'b1, 1'b0, 1'b0, 8'h22);
      drive(1'b1, 1'b0, 1'b0, 8'h33);
      checks++;
      if ({hdr_done, type_onehot, type_unknown, runt_err} !== 5'b1_10_0_0) begin
         errors++;
         $display("FAIL restart_decode got %b want 11000",
                  {hdr_done, type_onehot, type_unknown, runt_err});
      end
      checks++;
      if (hdr_data !== 32'h01112233) begin
         errors++;
         $display("FAIL restart_hdr_data got %h want 01112233", hdr_data);
      end
      drive(1'b1, 1'b0, 1'b1, 8'h44);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b111, 8'h44}) begin
         errors++;
         $display("FAIL restart_pay got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b111, 8'h44});
      end
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'hFF);
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      drive(1'b0, 1'b0, 1'b0, 8'hFF);
      drive(1'b0, 1'b1, 1'b1, 8'hFF);
      drive(1'b1, 1'b0, 1'b0, 8'hBB);
      checks++;
      if (hdr_done !== 1'b0) begin
         errors++;
         $display("FAIL gap_early_done got %b want 0", hdr_done);
      end
      drive(1'b1, 1'b0, 1'b0, 8'hCC);
      checks++;
      if ({hdr_done, type_onehot, hdr_data} !== {1'b1, 2'b01, 32'h00AABBCC}) begin
         errors++;
         $display("FAIL gap_decode got %h want %h", {hdr_done, type_onehot, hdr_data},
                  {1'b1, 2'b01, 32'h00AABBCC});
      end
      drive(1'b0, 1'b0, 1'b0, 8'hFF);
      checks++;
      if ({hdr_done, out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL gap_pulse got %b want 00", {hdr_done, out_valid});
      end
      drive(1'b1, 1'b0, 1'b0, 8'h11);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b110, 8'h11}) begin
         errors++;
         $display("FAIL gap_pay0 got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b110, 8'h11});
      end
      drive(1'b0, 1'b0, 1'b0, 8'hFF);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_pay_gap out_valid got %b want 0", out_valid);
      end
      drive(1'b1, 1'b0, 1'b1, 8'h22);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b101, 8'h22}) begin
         errors++;
         $display("FAIL gap_pay1 got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b101, 8'h22});
      end
      drive(1'b1, 1'b1, 1'b0, 8'h01);
      checks++;
      if ({out_valid, runt_err} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_sop got %b want 00", {out_valid, runt_err});
      end
      drive(1'b1, 1'b0, 1'b0, 8'hDD);
      drive(1'b1, 1'b0, 1'b0, 8'hEE);
      drive(1'b1, 1'b0, 1'b0, 8'hFF);
      checks++;
      if ({hdr_done, type_onehot, hdr_data} !== {1'b1, 2'b10, 32'h01DDEEFF}) begin
         errors++;
         $display("FAIL b2b_decode got %h want %h", {hdr_done, type_onehot, hdr_data},
                  {1'b1, 2'b10, 32'h01DDEEFF});
      end
      drive(1'b1, 1'b0, 1'b1, 8'h33);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b111, 8'h33}) begin
         errors++;
         $display("FAIL b2b_pay got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b111, 8'h33});
      end
   endtask

`ifdef HDR_LEN_CHECK_EN
   task automatic test_len;
      for (int n = 2; n <= 3; n++) begin
         drive(1'b1, 1'b1, 1'b0, 8'h00);
         drive(1'b1, 1'b0, 1'b0, 8'h02);
         drive(1'b1, 1'b0, 1'b0, 8'hBB);
         drive(1'b1, 1'b0, 1'b0, 8'hCC);
         for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, (i == n - 1), 8'h60 + 8'(i));
         end
         checks++;
         if ({out_eop, len_err} !== {1'b1, (n != 2)}) begin
            errors++;
            $display("FAIL len_check beats %0d got %b want %b", n, {out_eop, len_err},
                     {1'b1, (n != 2)});
         end
      end
   endtask
`endif

   task automatic test_reset_mid_pass;
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'hAA);
      drive(1'b1, 1'b0, 1'b0, 8'hBB);
      drive(1'b1, 1'b0, 1'b0, 8'hCC);
      drive(1'b1, 1'b0, 1'b0, 8'h11);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset out_valid got %b want 1", out_valid);
      end
      sclr_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h22);
      sclr_n = 1'b1;
      checks++;
      if ({out_valid, out_sop, out_eop, out_data, hdr_done, type_onehot, type_unknown,
           runt_err, len_err, hdr_data} !== 49'd0) begin
         errors++;
         $display("FAIL mid_reset got %h want 0", {out_valid, out_sop, out_eop, out_data,
                  hdr_done, type_onehot, type_unknown, runt_err, len_err, hdr_data});
      end
      drive(1'b1, 1'b0, 1'b1, 8'h33);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_stray out_valid got %b want 0", out_valid);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h01);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h12);
      drive(1'b1, 1'b0, 1'b0, 8'h34);
      checks++;
      if ({hdr_done, type_onehot, type_unknown, hdr_data} !== {4'b1_10_0, 32'h01001234}) begin
         errors++;
         $display("FAIL post_reset_decode got %h want %h",
                  {hdr_done, type_onehot, type_unknown, hdr_data}, {4'b1_10_0, 32'h01001234});
      end
      drive(1'b1, 1'b0, 1'b1, 8'h55);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {3'b111, 8'h55}) begin
         errors++;
         $display("FAIL post_reset_pay got %b want %b", {out_valid, out_sop, out_eop, out_data},
                  {3'b111, 8'h55});
      end
   endtask

   initial begin
      sclr_n   = 1'b0;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_known();
      test_unknown();
      test_runt_eop();
      test_runt_restart();
      test_back_to_back();
`ifdef HDR_LEN_CHECK_EN
      test_len();
`endif
      test_reset_mid_pass();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
